// File: rtl/yolo_sched_pkg.sv
// Shared definitions for the region-layer activation sequencer.
// Holds the controller state encoding, default widths and credit limit, and
// a packed element-index view {n, i, j} at the default index width.
package yolo_sched_pkg;

  localparam int unsigned DefDimW   = 8;   // width of each loop bound / index
  localparam int unsigned DefAddrW  = 16;  // width of the linear element address
  localparam int unsigned DefMaxOut = 9;   // engine pipeline depth = credit limit
  localparam int unsigned DefCntW   = 4;   // outstanding counter, 2^CntW > MaxOut

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [DefDimW-1:0] n;
    logic [DefDimW-1:0] i;
    logic [DefDimW-1:0] j;
  } elem_idx_t;

endpackage

// File: rtl/yolo_idx_counter.sv
// Three-level nested wrap counter for the anchor/row/column loop nest.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   clear               zero all indices and the linear address
//   advance             step to the next element (j fastest, then i, then n)
//   bound_n/h/w         loop bounds, held stable while advancing
//   n, i, j             current element indices
//   addr                linear address ((n*H)+i)*W+j, wraps modulo 2^ADDR_W
//   last                current element is the final one of the nest
module yolo_idx_counter #(
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  bound_n,
  input  logic [DIM_W-1:0]  bound_h,
  input  logic [DIM_W-1:0]  bound_w,
  output logic [DIM_W-1:0]  n,
  output logic [DIM_W-1:0]  i,
  output logic [DIM_W-1:0]  j,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0]  n_q, n_d, i_q, i_d, j_q, j_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_n, wrap_i, wrap_j;

  assign wrap_j = (j_q == bound_w - DIM_W'(1));
  assign wrap_i = (i_q == bound_h - DIM_W'(1));
  assign wrap_n = (n_q == bound_n - DIM_W'(1));

  // Address is a separate running counter rather than a product, so no multiplier.
  always_comb begin
    n_d    = n_q;
    i_d    = i_q;
    j_d    = j_q;
    addr_d = addr_q;
    if (clear) begin
      n_d    = '0;
      i_d    = '0;
      j_d    = '0;
      addr_d = '0;
    end else if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
      if (wrap_j) begin
        j_d = '0;
        if (wrap_i) begin
          i_d = '0;
          n_d = n_q + DIM_W'(1);
        end else begin
          i_d = i_q + DIM_W'(1);
        end
      end else begin
        j_d = j_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      addr_q <= '0;
    end else begin
      n_q    <= n_d;
      i_q    <= i_d;
      j_q    <= j_d;
      addr_q <= addr_d;
    end
  end

  assign n    = n_q;
  assign i    = i_q;
  assign j    = j_q;
  assign addr = addr_q;
  assign last = wrap_n && wrap_i && wrap_j;

endmodule

// File: rtl/yolo_region_sched.sv
// Sequencing controller for the region-layer activation datapath.
// Walks the n/i/j loop nest, issues one request per element to the pipelined
// activation engine under a credit limit, counts returned results and reports
// completion with an ap_ctrl_hs start/done/idle/ready handshake.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready block-level handshake
//   cfg_n/h/w                         loop bounds, latched on an accepted start
//   req_valid/req_ready               request handshake to the engine
//   req_addr/req_n/req_i/req_j        element address and indices
//   req_last                          final element of the nest
//   rsp_valid                         engine completed one element
//   err                               sticky: response seen with nothing outstanding
module yolo_region_sched
  import yolo_sched_pkg::*;
#(
  parameter int unsigned DIM_W   = DefDimW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned MAX_OUT = DefMaxOut,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DIM_W-1:0]  req_n,
  output logic [DIM_W-1:0]  req_i,
  output logic [DIM_W-1:0]  req_j,
  output logic              req_last,
  input  logic              rsp_valid,
  output logic              err
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] bnd_n_q, bnd_h_q, bnd_w_q;
  logic [CNT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;  // current run had an empty loop nest
  logic             take_start, accept, bound_zero;

  assign bound_zero = (cfg_n == '0) || (cfg_h == '0) || (cfg_w == '0);

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    err_d      = err_q;
    zero_d     = zero_q;
    take_start = 1'b0;
    req_valid  = 1'b0;
    ap_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          take_start = 1'b1;
          zero_d     = bound_zero;
          state_d    = bound_zero ? StDone : StIssue;
        end
      end
      StIssue: begin
        // Credit check uses the registered count only: a response this cycle
        // frees a slot next cycle, keeping rsp_valid off the req_valid path.
        req_valid = (out_q < CNT_W'(MAX_OUT));
        if (req_valid && req_ready && req_last) begin
          ap_ready = 1'b1;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if ((out_q == '0) || ((out_q == CNT_W'(1)) && rsp_valid)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // An empty nest has no final accept, so ready pulses alongside done.
        ap_ready = zero_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    accept = req_valid && req_ready;

    if (take_start) err_d = 1'b0;
    if (rsp_valid && (out_q == '0)) err_d = 1'b1;

    if (accept && !rsp_valid) begin
      out_d = out_q + CNT_W'(1);
    end else if (!accept && rsp_valid && (out_q != '0)) begin
      out_d = out_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      bnd_n_q <= '0;
      bnd_h_q <= '0;
      bnd_w_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      if (take_start) begin
        bnd_n_q <= cfg_n;
        bnd_h_q <= cfg_h;
        bnd_w_q <= cfg_w;
      end
    end
  end

  yolo_idx_counter #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clock   (clock),
    .reset   (reset),
    .clear   (take_start),
    .advance (accept),
    .bound_n (bnd_n_q),
    .bound_h (bnd_h_q),
    .bound_w (bnd_w_q),
    .n       (req_n),
    .i       (req_i),
    .j       (req_j),
    .addr    (req_addr),
    .last    (req_last)
  );

  assign ap_done = (state_q == StDone);
  assign ap_idle = (state_q == StIdle);
  assign err     = err_q;

endmodule

// File: tb/tb_yolo_region_sched.sv
// Self-checking bench for yolo_region_sched: a behavioural model derives every
// expected output from element number k and the credit count, and is checked
// against the DUT each cycle, with literal expectations pinning directed cases.
module tb_yolo_region_sched;
  import yolo_sched_pkg::*;

  localparam int MaxOut = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [7:0]  cfg_n = 8'd0, cfg_h = 8'd0, cfg_w = 8'd0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [15:0] req_addr;
  logic [7:0]  req_n, req_i, req_j;
  logic        req_last;
  logic        rsp_valid = 1'b0;
  logic        err;

  always #5 clock = ~clock;

  yolo_region_sched dut (
    .clock     (clock),
    .reset     (reset),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .cfg_n     (cfg_n),
    .cfg_h     (cfg_h),
    .cfg_w     (cfg_w),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_n     (req_n),
    .req_i     (req_i),
    .req_j     (req_j),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls
  int  cyc = 0;
  bit  rdy_rand = 1'b0;
  bit  rdy_val = 1'b0;
  int  rsp_mode = 0;       // 0: none, 1: fixed/random latency, 2: return whenever outstanding
  int  lat_min = 1, lat_max = 1;
  bit  inj_rsp = 1'b0;
  int  due_q[$];

  // Model state
  int  m_phase = 0;        // 0 idle, 1 issuing, 2 draining, 3 done
  int  m_k = 0, m_total = 0, m_h = 0, m_w = 0, m_out = 0;
  bit  m_err = 1'b0, m_zero = 1'b0;

  // Monitor records
  int  acc_cnt = 0, last_cnt = 0, done_cnt = 0, ready_cyc = 0, done_cyc = 0;
  int  acc_addr[$];
  int  acc_ij[$];

  // Inputs change 2 time units after the rising edge.
  initial begin
    bit r;
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : rdy_val;
      r = inj_rsp;
      if (rsp_mode == 1 && due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        r = 1'b1;
      end
      if (rsp_mode == 2 && m_out > 0) r = 1'b1;
      rsp_valid = r;
    end
  end

  // Model + compare on the falling edge, then advance the model using the
  // inputs that the next rising edge will sample.
  initial begin
    bit        e_valid, e_acc, e_last;
    elem_idx_t e_idx;
    int        hw;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_phase = 0; m_k = 0; m_out = 0; m_err = 1'b0; m_zero = 1'b0;
      end
      e_valid = (m_phase == 1) && (m_out < MaxOut);
      e_acc   = e_valid && req_ready;
      e_last  = (m_k == m_total - 1);
      hw      = (m_h * m_w == 0) ? 1 : m_h * m_w;
      e_idx.n = 8'(m_k / hw);
      e_idx.i = 8'((m_k / ((m_w == 0) ? 1 : m_w)) % ((m_h == 0) ? 1 : m_h));
      e_idx.j = 8'(m_k % ((m_w == 0) ? 1 : m_w));

      check("ap_idle", 32'(ap_idle), 32'(m_phase == 0));
      check("ap_done", 32'(ap_done), 32'(m_phase == 3));
      check("ap_ready", 32'(ap_ready),
            32'((e_acc && e_last) || (m_phase == 3 && m_zero)));
      check("req_valid", 32'(req_valid), 32'(e_valid));
      check("err", 32'(err), 32'(m_err));
      if (e_valid) begin
        check("req_addr", 32'(req_addr), 32'(m_k % 65536));
        check("req_n", 32'(req_n), 32'(e_idx.n));
        check("req_i", 32'(req_i), 32'(e_idx.i));
        check("req_j", 32'(req_j), 32'(e_idx.j));
        check("req_last", 32'(req_last), 32'(e_last));
      end

      if (req_valid === 1'b1 && req_ready) begin
        acc_cnt++;
        acc_addr.push_back(int'(req_addr));
        acc_ij.push_back(int'({req_i[3:0], req_j[3:0]}));
        if (req_last) last_cnt++;
      end
      if (ap_ready === 1'b1) ready_cyc = cyc;
      if (ap_done === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
      end

      if (!reset) begin
        if (m_phase == 0) begin
          if (ap_start) begin
            m_h = cfg_h; m_w = cfg_w;
            m_total = int'(cfg_n) * int'(cfg_h) * int'(cfg_w);
            m_k = 0; m_err = 1'b0;
            m_zero = (m_total == 0);
            m_phase = m_zero ? 3 : 1;
          end
        end else if (m_phase == 1) begin
          if (e_acc) begin
            if (e_last) m_phase = 2;
            m_k++;
          end
        end else if (m_phase == 2) begin
          if (m_out == 0 || (m_out == 1 && rsp_valid)) m_phase = 3;
        end else begin
          m_phase = 0;
        end
        if (rsp_valid && m_out == 0) m_err = 1'b1;
        m_out = m_out + (e_acc ? 1 : 0) - ((rsp_valid && m_out > 0) ? 1 : 0);
        if (e_acc && rsp_mode == 1) due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int n, input int h, input int w);
    tick();
    cfg_n = 8'(n); cfg_h = 8'(h); cfg_w = 8'(w);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int target = done_cnt + 1;
    int t = 0;
    while (done_cnt < target && t < max_cyc) begin
      tick();
      t++;
    end
    check({name, " done within bound"}, 32'(done_cnt >= target), 32'd1);
    tick();
  endtask

  task automatic clear_log();
    acc_cnt = 0; last_cnt = 0;
    acc_addr.delete();
    acc_ij.delete();
  endtask

  initial begin
    int exp_ij[6] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
    int bad, dn;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst ap_idle", 32'(ap_idle), 32'd1);
    check("rst ap_done", 32'(ap_done), 32'd0);
    check("rst ap_ready", 32'(ap_ready), 32'd0);
    check("rst req_valid", 32'(req_valid), 32'd0);
    check("rst req_addr", 32'(req_addr), 32'd0);
    check("rst req_nij", 32'({req_n, req_i, req_j}), 32'd0);
    check("rst err", 32'(err), 32'd0);
    reset = 1'b0;

    // 1x2x3, fixed 9-cycle response latency
    clear_log();
    rdy_rand = 1'b0; rdy_val = 1'b1; rsp_mode = 1; lat_min = 9; lat_max = 9;
    start_run(1, 2, 3);
    wait_done("A", 200);
    check("A accepts", 32'(acc_cnt), 32'd6);
    for (int k = 0; k < 6 && k < acc_addr.size(); k++) begin
      check("A addr", 32'(acc_addr[k]), 32'(k));
      check("A ij", 32'(acc_ij[k]), 32'(exp_ij[k]));
    end
    check("A last count", 32'(last_cnt), 32'd1);
    check("A ready->done gap", 32'(done_cyc - ready_cyc), 32'd10);

    // 3x4x4, no responses: credit limit
    clear_log();
    rsp_mode = 0;
    start_run(3, 4, 4);
    repeat (20) tick();
    check("B credit cap", 32'(acc_cnt), 32'd9);
    check("B valid low", 32'(req_valid), 32'd0);
    inj_rsp = 1'b1; tick(); inj_rsp = 1'b0;
    repeat (5) tick();
    check("B one more", 32'(acc_cnt), 32'd10);
    rdy_val = 1'b0; inj_rsp = 1'b1; tick(); inj_rsp = 1'b0;
    tick();
    check("B valid at 8", 32'(req_valid), 32'd1);
    rdy_val = 1'b1; inj_rsp = 1'b1; tick();
    inj_rsp = 1'b0; rdy_val = 1'b0;
    check("B acc+rsp keeps count", 32'(req_valid), 32'd1);
    rdy_val = 1'b1; tick();
    check("B back to cap", 32'(req_valid), 32'd0);
    check("B accepts", 32'(acc_cnt), 32'd12);
    rsp_mode = 2;
    wait_done("B", 400);
    rsp_mode = 0;

    // Empty nest
    clear_log();
    start_run(2, 2, 0);
    check("Z ap_done", 32'(ap_done), 32'd1);
    check("Z ap_ready", 32'(ap_ready), 32'd1);
    check("Z req_valid", 32'(req_valid), 32'd0);
    tick();
    check("Z idle again", 32'(ap_idle), 32'd1);
    check("Z done once", 32'(ap_done), 32'd0);

    // Spurious response in idle sets err; next start clears it
    inj_rsp = 1'b1; tick(); inj_rsp = 1'b0; tick();
    check("E err set", 32'(err), 32'd1);
    rsp_mode = 1; lat_min = 3; lat_max = 3;
    start_run(1, 1, 2);
    check("E err cleared", 32'(err), 32'd0);
    wait_done("E", 100);

    // 3x8x8 with random ready and random latency
    clear_log();
    rdy_rand = 1'b1; lat_min = 1; lat_max = 12;
    start_run(3, 8, 8);
    wait_done("R", 4000);
    rdy_rand = 1'b0;
    check("R accepts", 32'(acc_cnt), 32'd192);
    bad = 0;
    for (int k = 0; k < acc_addr.size(); k++) if (acc_addr[k] != k) bad++;
    check("R addr sequence", 32'(bad), 32'd0);
    check("R last count", 32'(last_cnt), 32'd1);

    // Async reset mid-issue with 5 outstanding
    clear_log();
    rsp_mode = 0; rdy_val = 1'b1;
    start_run(3, 4, 4);
    for (int t = 0; t < 50 && acc_cnt < 5; t++) begin
      @(negedge clock);
      #1;
    end
    rdy_val = 1'b0;
    dn = done_cnt;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("X req_valid", 32'(req_valid), 32'd0);
    check("X ap_idle", 32'(ap_idle), 32'd1);
    check("X req_addr", 32'(req_addr), 32'd0);
    check("X req_nij", 32'({req_n, req_i, req_j}), 32'd0);
    check("X ap_ready", 32'(ap_ready), 32'd0);
    due_q.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("X no done", 32'(done_cnt), 32'(dn));
    clear_log();
    rdy_val = 1'b1; rsp_mode = 1; lat_min = 9; lat_max = 9;
    start_run(2, 3, 3);
    wait_done("X rerun", 300);
    check("X rerun accepts", 32'(acc_cnt), 32'd18);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
